// File: rtl/fc_layer_seq.sv
// fc_layer_seq
//   Time-multiplexed fully-connected layer. The input vector arrives one
//   element per accepted beat, and OUT_SIZE neurons accumulate weight*input
//   products in parallel. Words are signed fixed point with FRAC_W fraction
//   bits. After the last element the result vector is presented, saturated to
//   DATA_W bits, and held until the consumer takes it.
//
//   Weights and biases live in internal registers. They can only be written
//   while the layer is idle, meaning in ACCUM state before element 0 has been
//   taken.
//
//   Optional macro FC_RELU_EN: when defined, negative saturated results are
//   clamped to zero (ReLU).
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready/in_data     input element stream (index = beat count)
//   out_valid/out_ready/out_data  result vector, neuron j at [j*DATA_W +: DATA_W]
//   cfg_wr, cfg_is_bias, cfg_row, cfg_col, cfg_data  weight/bias write port
//   cfg_ready     high when a config write will take effect
module fc_layer_seq #(
  parameter int IN_SIZE  = 32,
  parameter int OUT_SIZE = 4,
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int ACC_W    = 40,
  localparam int ROW_W   = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1,
  localparam int COL_W   = $clog2(IN_SIZE)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_SIZE*DATA_W-1:0] out_data,
  input  logic                       cfg_wr,
  input  logic                       cfg_is_bias,
  input  logic [ROW_W-1:0]           cfg_row,
  input  logic [COL_W-1:0]           cfg_col,
  input  logic [DATA_W-1:0]          cfg_data,
  output logic                       cfg_ready
);

  localparam int PROD_W = 2 * DATA_W;

  // Saturation bounds of a DATA_W word, sign-extended to accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic {ACCUM, DONE} state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [COL_W-1:0]         count;
  logic signed [DATA_W-1:0] x_s;
  logic                     accept;
  logic                     last_beat;
  logic                     cfg_fire;

  assign x_s       = in_data;
  assign accept    = in_valid && in_ready;
  assign last_beat = (count == COL_W'(IN_SIZE - 1));
  assign cfg_fire  = cfg_wr && cfg_ready;

  // State register. The layer is either collecting elements or presenting a
  // finished result vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs. Configuration is only allowed in ACCUM
  // before element 0, so a partial sum never mixes old and new weights.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    cfg_ready = 1'b0;
    case (state)
      ACCUM: begin
        in_ready  = 1'b1;
        cfg_ready = (count == '0);
        if (accept && last_beat) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // Beat counter. It indexes the weight column for the current element and
  // wraps to zero after the last element of a vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (accept) begin
      if (last_beat) count <= '0;
      else           count <= count + 1'b1;
    end
  end

  for (genvar j = 0; j < OUT_SIZE; j++) begin : g_neuron
    logic signed [DATA_W-1:0] w_row [IN_SIZE];
    logic signed [DATA_W-1:0] bias_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [DATA_W-1:0] out_q;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_base;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic signed [ACC_W-1:0]  acc_shr;
    logic signed [DATA_W-1:0] res;

    // One register per weight. A write is ignored unless both the row and
    // the column decode exactly, so out-of-range addresses have no effect.
    for (genvar k = 0; k < IN_SIZE; k++) begin : g_w
      logic signed [DATA_W-1:0] w_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          w_q <= '0;
        else if (cfg_fire && !cfg_is_bias &&
                 cfg_row == ROW_W'(j) && cfg_col == COL_W'(k))
          w_q <= cfg_data;
      end
      assign w_row[k] = w_q;
    end

    // Bias register. Bias writes decode on the row only.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        bias_q <= '0;
      else if (cfg_fire && cfg_is_bias && cfg_row == ROW_W'(j))
        bias_q <= cfg_data;
    end

    // Multiply-accumulate for this neuron. Element 0 seeds the sum with the
    // bias aligned to the product's fixed-point position, which replaces a
    // separate clear step. The result path shifts right arithmetically, which
    // floors, and then saturates to the DATA_W range.
    always_comb begin
      prod     = PROD_W'(w_row[count]) * PROD_W'(x_s);
      acc_base = (count == '0) ? (ACC_W'(bias_q) <<< FRAC_W) : acc_q;
      acc_nxt  = acc_base + ACC_W'(prod);
      acc_shr  = acc_nxt >>> FRAC_W;
      if (acc_shr > SAT_MAX)      res = SAT_MAX[DATA_W-1:0];
      else if (acc_shr < SAT_MIN) res = SAT_MIN[DATA_W-1:0];
      else                        res = acc_shr[DATA_W-1:0];
`ifdef FC_RELU_EN
      if (res[DATA_W-1]) res = '0;
`endif
    end

    // Accumulator and output registers. The output word is captured on the
    // final beat, so it stays stable through DONE regardless of input activity.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc_q <= '0;
        out_q <= '0;
      end else if (accept) begin
        acc_q <= acc_nxt;
        if (last_beat) out_q <= res;
      end
    end

    assign out_data[j*DATA_W +: DATA_W] = out_q;
  end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Testbench for fc_layer_seq. It uses randomized and directed vectors checked
// against an arithmetic reference model of the layer.
module tb_fc_layer_seq;

  localparam int IN  = 32;
  localparam int OUT = 4;
  localparam int DW  = 16;
  localparam int FW  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic            out_valid;
  logic            out_ready;
  logic [OUT*DW-1:0] out_data;
  logic            cfg_wr;
  logic            cfg_is_bias;
  logic [1:0]      cfg_row;
  logic [4:0]      cfg_col;
  logic [DW-1:0]   cfg_data;
  logic            cfg_ready;

  int checks;
  int failures;

  // Reference model state
  logic signed [DW-1:0] w_m [OUT][IN];
  logic signed [DW-1:0] b_m [OUT];
  logic signed [DW-1:0] x_vec [IN];
  logic [DW-1:0]        exp_v [OUT];

  fc_layer_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_wr(cfg_wr), .cfg_is_bias(cfg_is_bias), .cfg_row(cfg_row),
    .cfg_col(cfg_col), .cfg_data(cfg_data), .cfg_ready(cfg_ready)
  );

  always #5 clk = ~clk;

  // Plain integer evaluation of one neuron: bias plus the dot product,
  // floored to integer-part scale, saturated, then optionally rectified.
  function automatic logic [DW-1:0] ref_neuron(int j);
    longint sum;
    longint q;
    sum = longint'(b_m[j]) * 256;
    for (int i = 0; i < IN; i++)
      sum += longint'(w_m[j][i]) * longint'(x_vec[i]);
    q = sum >>> FW;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
`ifdef FC_RELU_EN
    if (q < 0) q = 0;
`endif
    return 16'(q);
  endfunction

  task automatic model_clear();
    for (int j = 0; j < OUT; j++) begin
      b_m[j] = '0;
      for (int i = 0; i < IN; i++) w_m[j][i] = '0;
    end
  endtask

  task automatic cfg_write(input int row, input int col, input bit is_bias,
                           input logic [DW-1:0] d);
    cfg_wr = 1'b1; cfg_is_bias = is_bias; cfg_row = 2'(row);
    cfg_col = 5'(col); cfg_data = d;
    @(negedge clk);
    cfg_wr = 1'b0;
    if (is_bias) b_m[row] = d;
    else         w_m[row][col] = d;
  endtask

  task automatic load_all(input logic [DW-1:0] wv, input logic [DW-1:0] bv);
    for (int j = 0; j < OUT; j++)
      for (int i = 0; i < IN; i++) cfg_write(j, i, 1'b0, wv);
    for (int j = 0; j < OUT; j++) cfg_write(j, 0, 1'b1, bv);
  endtask

  task automatic fill_x(input logic [DW-1:0] v);
    for (int i = 0; i < IN; i++) x_vec[i] = v;
  endtask

  // Streams x_vec, optionally issuing a config write (row cr, column = beat
  // index) alongside beat cfg_beat. Only a write on beat 0 is expected to land.
  // Ends on the first negedge after the last beat, with the DUT in DONE.
  task automatic stream_vector(input string tag, input int max_gap,
                               input int cfg_beat, input int cr,
                               input logic [DW-1:0] cd);
    for (int j = 0; j < OUT; j++) exp_v[j] = ref_neuron(j);
    for (int i = 0; i < IN; i++) begin
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL %s beat%0d handshake: got in_ready=%b out_valid=%b expected 1/0",
                 tag, i, in_ready, out_valid);
      end
      if (i == cfg_beat) begin
        checks++;
        if (cfg_ready !== (i == 0)) begin
          failures++;
          $display("[TB] FAIL %s cfg_ready at beat%0d: got %b expected %b",
                   tag, i, cfg_ready, (i == 0));
        end
        cfg_wr = 1'b1; cfg_is_bias = 1'b0; cfg_row = 2'(cr);
        cfg_col = 5'(i); cfg_data = cd;
      end
      in_valid = 1'b1;
      in_data  = x_vec[i];
      @(negedge clk);
      in_valid = 1'b0;
      if (i == cfg_beat) begin
        cfg_wr = 1'b0;
        if (i == 0) w_m[cr][0] = cd;
      end
      if (i < IN - 1) repeat ($urandom_range(max_gap)) @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || cfg_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s done flags: got out_valid=%b in_ready=%b cfg_ready=%b expected 1/0/0",
               tag, out_valid, in_ready, cfg_ready);
    end
    for (int j = 0; j < OUT; j++) begin
      checks++;
      if (out_data[j*DW +: DW] !== exp_v[j]) begin
        failures++;
        $display("[TB] FAIL %s neuron%0d: got %h expected %h",
                 tag, j, out_data[j*DW +: DW], exp_v[j]);
      end
    end
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s in_ready before consume: got %b expected 0", tag, in_ready);
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || cfg_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s after consume: got in_ready=%b out_valid=%b cfg_ready=%b expected 1/0/1",
               tag, in_ready, out_valid, cfg_ready);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1 || cfg_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset outputs: got out_valid=%b out_data=%h in_ready=%b cfg_ready=%b expected 0/0/1/1",
               out_valid, out_data, in_ready, cfg_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      failures++;
      $display("[TB] FAIL post-reset idle: got out_valid=%b out_data=%h expected 0/0",
               out_valid, out_data);
    end
  endtask

  task automatic test_unity();
    load_all(16'h0100, 16'h0000);
    fill_x(16'h0100);
    stream_vector("unity", 0, -1, 0, '0);
    checks++;
    if (out_data[15:0] !== 16'h2000) begin
      failures++;
      $display("[TB] FAIL unity const: got %h expected 2000", out_data[15:0]);
    end
    consume("unity");
  endtask

  task automatic test_saturation();
    load_all(16'h7FFF, 16'h7FFF);
    fill_x(16'h7FFF);
    stream_vector("saturation", 1, -1, 0, '0);
    checks++;
    if (out_data[31:16] !== 16'h7FFF) begin
      failures++;
      $display("[TB] FAIL saturation const: got %h expected 7fff", out_data[31:16]);
    end
    consume("saturation");
  endtask

  task automatic test_negative();
    logic [DW-1:0] want;
`ifdef FC_RELU_EN
    want = 16'h0000;
`else
    want = 16'hC000;
`endif
    load_all(16'hFF00, 16'h0000);
    fill_x(16'h0200);
    stream_vector("negative", 1, -1, 0, '0);
    checks++;
    if (out_data[63:48] !== want) begin
      failures++;
      $display("[TB] FAIL negative const: got %h expected %h", out_data[63:48], want);
    end
    consume("negative");
  endtask

  task automatic test_bias();
    load_all(16'h0100, 16'h0000);
    cfg_write(2, 0, 1'b1, 16'h0180);
    fill_x(16'h0100);
    stream_vector("bias", 0, -1, 0, '0);
    checks++;
    if (out_data[47:32] !== 16'h2180 || out_data[31:16] !== 16'h2000) begin
      failures++;
      $display("[TB] FAIL bias const: got n2=%h n1=%h expected 2180/2000",
               out_data[47:32], out_data[31:16]);
    end
    consume("bias");
  endtask

  task automatic test_hold();
    load_all(16'h0100, 16'h0000);
    fill_x(16'h0100);
    stream_vector("hold", 0, -1, 0, '0);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || cfg_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL hold flags cycle%0d: got out_valid=%b in_ready=%b cfg_ready=%b expected 1/0/0",
                 c, out_valid, in_ready, cfg_ready);
      end
      for (int j = 0; j < OUT; j++) begin
        checks++;
        if (out_data[j*DW +: DW] !== exp_v[j]) begin
          failures++;
          $display("[TB] FAIL hold neuron%0d cycle%0d: got %h expected %h",
                   j, c, out_data[j*DW +: DW], exp_v[j]);
        end
      end
      if (c == 3) begin
        cfg_wr = 1'b1; cfg_is_bias = 1'b0; cfg_row = 2'd0; cfg_col = 5'd0;
        cfg_data = 16'h7FFF;
      end
      if (c == 5) begin
        cfg_wr = 1'b1; cfg_is_bias = 1'b1; cfg_row = 2'd1; cfg_data = 16'h4000;
        in_valid = 1'b1; in_data = 16'h7FFF;
      end
      @(negedge clk);
      cfg_wr = 1'b0;
      in_valid = 1'b0;
    end
    consume("hold");
    stream_vector("hold-after", 0, -1, 0, '0);
    consume("hold-after");
  endtask

  task automatic test_cfg_timing();
    load_all(16'h0100, 16'h0000);
    fill_x(16'h0100);
    stream_vector("cfg-first-beat", 0, 0, 1, 16'h0300);
    consume("cfg-first-beat");
    stream_vector("cfg-mid", 1, 5, 0, 16'h7FFF);
    checks++;
    if (out_data[31:16] !== 16'h2200) begin
      failures++;
      $display("[TB] FAIL cfg-first-beat new weight: got %h expected 2200", out_data[31:16]);
    end
    consume("cfg-mid");
    stream_vector("cfg-mid-after", 0, -1, 0, '0);
    checks++;
    if (out_data[15:0] !== 16'h2000) begin
      failures++;
      $display("[TB] FAIL cfg-mid ignored: got %h expected 2000", out_data[15:0]);
    end
    consume("cfg-mid-after");
  endtask

  task automatic test_reset_mid();
    load_all(16'h0100, 16'h0000);
    fill_x(16'h0100);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = x_vec[i];
      @(negedge clk);
      in_valid = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1 || cfg_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid reset: got out_valid=%b out_data=%h in_ready=%b cfg_ready=%b expected 0/0/1/1",
               out_valid, out_data, in_ready, cfg_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    load_all(16'h0100, 16'h0000);
    stream_vector("after-reset", 1, -1, 0, '0);
    checks++;
    if (out_data[15:0] !== 16'h2000) begin
      failures++;
      $display("[TB] FAIL after-reset const: got %h expected 2000", out_data[15:0]);
    end
    consume("after-reset");
  endtask

  task automatic test_random();
    for (int v = 0; v < 6; v++) begin
      for (int j = 0; j < OUT; j++) begin
        for (int i = 0; i < IN; i++) begin
          if (v % 3 == 2) cfg_write(j, i, 1'b0, 16'($urandom));
          else            cfg_write(j, i, 1'b0, 16'(int'($urandom_range(1023)) - 512));
        end
        cfg_write(j, 0, 1'b1, 16'(int'($urandom_range(4095)) - 2048));
      end
      for (int i = 0; i < IN; i++) begin
        if (v % 3 == 1) x_vec[i] = 16'($urandom);
        else            x_vec[i] = 16'(int'($urandom_range(2047)) - 1024);
      end
      stream_vector("random", 2, -1, 0, '0);
      repeat ($urandom_range(3)) begin
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data[15:0] !== exp_v[0]) begin
          failures++;
          $display("[TB] FAIL random hold: got out_valid=%b n0=%h expected 1/%h",
                   out_valid, out_data[15:0], exp_v[0]);
        end
      end
      consume("random");
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cfg_wr = 1'b0; cfg_is_bias = 1'b0; cfg_row = '0; cfg_col = '0; cfg_data = '0;
    model_clear();
    repeat (2) @(negedge clk);
    test_reset();
    test_unity();
    test_saturation();
    test_negative();
    test_bias();
    test_hold();
    test_cfg_timing();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fc_layer_seq.md
Name: fc_layer_seq

Overview:
- Sequential, time-multiplexed fully-connected layer: one input-vector element streamed per beat; OUT_SIZE neurons accumulate in parallel.
- Signed fixed-point (Q format with FRAC_W fraction bits).
- Weights and biases held in internal registers, loaded over a config port.
- Successor to the combinational single-neuron FMA chain: adds a valid/ready handshake, multiple output neurons, bias, saturation and width/depth parameters.

Parameters:
- IN_SIZE, 32: elements per input vector (>=2).
- OUT_SIZE, 4: output neurons.
- DATA_W, 16: width of input, weight, bias and output words (two's complement).
- FRAC_W, 8: fraction bits of all DATA_W words.
- ACC_W, 40: accumulator width; must be >= 2*DATA_W + clog2(IN_SIZE) + 1 (no accumulator overflow handling).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input element valid
- in_ready  output  1  element accepted when in_valid && in_ready
- in_data  input  DATA_W  input element, index = internal beat count
- out_valid  output  1  result vector valid
- out_ready  input  1  result consumed when out_valid && out_ready
- out_data  output  OUT_SIZE*DATA_W  neuron j at [j*DATA_W +: DATA_W]
- cfg_wr  input  1  config write strobe
- cfg_is_bias  input  1  1 = bias write (cfg_col ignored), 0 = weight write
- cfg_row  input  clog2(OUT_SIZE)  neuron index
- cfg_col  input  clog2(IN_SIZE)  input index
- cfg_data  input  DATA_W  weight/bias value
- cfg_ready  output  1  config writes take effect only when high

Behaviour:
- Single clock clk. Asynchronous active-high reset rst.
- Reset values:
  - state = ACCUM, count = 0.
  - All accumulators, weights and biases = 0.
  - out_valid = 0, out_data = 0.
- State ACCUM:
  - in_ready = 1, out_valid = 0.
  - cfg_ready = 1 only while count == 0.
- Accepted beat, count == 0: acc[j] <= (sign-extended bias[j] << FRAC_W) + w[j][0]*in_data.
- Accepted beat, count > 0: acc[j] <= acc[j] + w[j][count]*in_data.
- count increments on every accepted beat.
- Beat with count == IN_SIZE-1: count <= 0 and state <= DONE.
- No in_valid: nothing changes; gaps between beats are allowed.
- State DONE:
  - in_ready = 0, cfg_ready = 0, out_valid = 1.
  - out_data[j] = sat(acc[j] >>> FRAC_W): arithmetic shift (truncation toward -inf), then saturation to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - out_data is held stable for as long as out_ready = 0.
- out_valid && out_ready: state <= ACCUM. in_ready rises the following cycle; there is no same-cycle pass-through.
- Latency: out_valid asserts the cycle after the last element is accepted. Minimum vector period is IN_SIZE+1 cycles.
- Config writes:
  - cfg_wr && cfg_ready: the addressed weight/bias register is updated at the clock edge.
  - cfg_wr while cfg_ready = 0: ignored, with no side effects.
  - Out-of-range row/col: ignored.
  - cfg_wr coincident with the first in_data beat (count == 0): the write takes effect at the same edge. The beat uses the old value.
- Mid-vector reset: all state clears immediately. The partial vector is discarded, and the next accepted beat is element 0.
- out_data is a registered/held value derived from the accumulators; it is not driven from live inputs.

Optional Feature:
- Macro FC_RELU_EN.
- Defined: after saturation each out_data[j] is clamped to 0 if negative (ReLU). Adds no latency.
- Undefined: signed saturated values are output unchanged.

Test Plan:
- Reset, then load all weights 0x0100 (1.0) and biases 0. Stream 32 beats of 0x0100 back-to-back -> out_valid on the cycle after beat 32; every neuron = 0x2000 (32.0).
- Weights 0x7FFF, inputs 0x7FFF, bias 0x7FFF -> every neuron saturates to 0x7FFF.
- Weights 0xFF00 (-1.0), inputs 0x0200, bias 0 -> 0xC000 (-64.0) with FC_RELU_EN undefined; 0x0000 with it defined.
- Neuron 2 bias 0x0180 (1.5), all other settings as test 1 -> neuron 2 = 0x2180, others 0x2000.
- Hold out_ready = 0 for 10 cycles in DONE -> out_data stable, in_ready = 0, a cfg_wr in this window is ignored. Then out_ready = 1 for one cycle -> in_ready = 1 the next cycle.
- Stream 10 beats, assert rst asynchronously mid-cycle -> outputs zero immediately. A following full vector of ones with weights reloaded gives 0x2000 (no leftover partial sum). A cfg_wr at count = 5 is ignored.
